// File: rtl/uart_pkg.sv
// Shared UART transmit types and constants: FSM state encoding, line levels,
// default payload width and a counter-width helper.
package uart_pkg;

    localparam int   UART_DEFAULT_DATA_WIDTH = 8;
    localparam logic UART_LINE_IDLE          = 1'b1;
    localparam logic UART_START_BIT          = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    // A single-bit payload still needs a one-bit counter to stay legal.
    function automatic int uart_cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter for the UART transmitter; ser_data_o
// is the bit the line should carry in the cycle after the current one.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    output logic                  ser_data_o,
    output logic                  ser_done_o
);

    localparam int CW = uart_cnt_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shift_q, shift_d, shifted;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_comb begin
        shifted = shift_q >> 1;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shift_d = load_data_i;
            cnt_d   = '0;
        end else if (shift_i) begin
            shift_d = shifted;
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // The line output is registered, so while shifting we must hand over the
    // bit that becomes bit 0 after this edge rather than the current one.
    assign ser_data_o = shift_i ? shifted[0] : shift_q[0];
    assign ser_done_o = (cnt_q == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit framing controller: start bit, LSB-first payload, optional
// parity, stop bit(s). Define UART_TX_STOP2_EN for two stop cycles.
module uart_tx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] p_data_i,
    input  logic                  data_valid_i,
    input  logic                  par_en_i,
    input  logic                  par_bit_i,
    output logic                  tx_out_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    uart_tx_state_t state_q, state_d;
    logic           par_en_q, par_en_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           ser_load, ser_shift, ser_data, ser_done;
`ifdef UART_TX_STOP2_EN
    logic [1:0]     stop_cnt_q, stop_cnt_d;
`endif

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (ser_load),
        .shift_i     (ser_shift),
        .load_data_i (p_data_i),
        .ser_data_o  (ser_data),
        .ser_done_o  (ser_done)
    );

    // Outputs are computed for the state being entered and registered with it.
    always_comb begin
        state_d   = state_q;
        par_en_d  = par_en_q;
        tx_d      = UART_LINE_IDLE;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
`ifdef UART_TX_STOP2_EN
        stop_cnt_d = stop_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (data_valid_i) begin
                    ser_load = 1'b1;
                    par_en_d = par_en_i;
                    state_d  = START;
                    tx_d     = UART_START_BIT;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                tx_d    = ser_data;
            end
            DATA: begin
                ser_shift = 1'b1;
                if (!ser_done) begin
                    tx_d = ser_data;
                end else if (par_en_q) begin
                    state_d = PARITY;
                    tx_d    = par_bit_i;
                end else begin
                    state_d = STOP;
`ifdef UART_TX_STOP2_EN
                    stop_cnt_d = 2'd0;
`endif
                end
            end
            PARITY: begin
                state_d = STOP;
`ifdef UART_TX_STOP2_EN
                stop_cnt_d = 2'd0;
`endif
            end
            STOP: begin
`ifdef UART_TX_STOP2_EN
                if (stop_cnt_q == 2'd1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    stop_cnt_d = stop_cnt_q + 2'd1;
                end
`else
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            par_en_q <= 1'b0;
            tx_q     <= UART_LINE_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            par_en_q <= par_en_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef UART_TX_STOP2_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stop_cnt_q <= 2'd0;
        end else begin
            stop_cnt_q <= stop_cnt_d;
        end
    end
`endif

    assign tx_out_o     = tx_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: directed frame table, corner
// sequences and randomized frames against a frame-level reference model.
module tb_uart_tx_frame_ctrl;

    localparam int W = 8;
`ifdef UART_TX_STOP2_EN
    localparam int STOP_CYCLES = 2;
`else
    localparam int STOP_CYCLES = 1;
`endif

    typedef logic bitq_t[$];

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pb;
        logic [0:11] expSeq;
        int          expLen;
        int          noiseAt;
        string       name;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] pData;
    logic       dataValid;
    logic       parEn;
    logic       parBit;
    logic       txOut;
    logic       busy;
    logic       frameDone;

    int checks = 0;
    int errors = 0;

    uart_tx_frame_ctrl #(
        .DATA_WIDTH (W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .p_data_i     (pData),
        .data_valid_i (dataValid),
        .par_en_i     (parEn),
        .par_bit_i    (parBit),
        .tx_out_o     (txOut),
        .busy_o       (busy),
        .frame_done_o (frameDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Whole-frame line image: start, payload LSB first, optional parity, stops.
    function automatic bitq_t modelFrame(input logic [7:0] d, input logic pe, input logic pb);
        bitq_t q;
        q.push_back(1'b0);
        for (int i = 0; i < W; i++) q.push_back(d[i]);
        if (pe) q.push_back(pb);
        for (int s = 0; s < STOP_CYCLES; s++) q.push_back(1'b1);
        return q;
    endfunction

    // Called at a negedge; the request is accepted on the following posedge.
    task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic pb,
                                 input bitq_t expBits, input bit keepValid,
                                 input int noiseAt, input string tag);
        pData     = d;
        parEn     = pe;
        parBit    = pb;
        dataValid = 1'b1;
        for (int i = 0; i < expBits.size(); i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s tx[%0d]", tag, i), txOut, expBits[i]);
            checkOutput($sformatf("%s busy[%0d]", tag, i), busy, 1'b1);
            checkOutput($sformatf("%s done[%0d]", tag, i), frameDone, 1'b0);
            if (!keepValid) begin
                dataValid = (i == noiseAt);
                pData     = (i == noiseAt) ? ~d : 8'($urandom);
                parEn     = 1'($urandom);
            end
        end
        @(negedge clk);
        checkOutput({tag, " idleTx"}, txOut, 1'b1);
        checkOutput({tag, " idleBusy"}, busy, 1'b0);
        checkOutput({tag, " frameDone"}, frameDone, 1'b1);
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput({tag, " idleTx"}, txOut, 1'b1);
            checkOutput({tag, " idleBusy"}, busy, 1'b0);
            checkOutput({tag, " idleDone"}, frameDone, 1'b0);
        end
    endtask

    initial begin
        vec_t  vecs[5];
        bitq_t q;
        logic [7:0] d;
        logic pe, pb;
        int noise;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 12'b010100101010, 11, -1, "a5Par"};
        vecs[1] = '{8'h0F, 1'b0, 1'b0, 12'b011110000100, 10, -1, "0fNoPar"};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 12'b000000000100, 10,  4, "00Ignore"};
        vecs[3] = '{8'h3C, 1'b1, 1'b0, 12'b000111100010, 11, -1, "3cPar"};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 12'b010000001110, 11,  0, "81Par1"};

        dataValid = 1'b0;
        pData     = 8'h00;
        parEn     = 1'b0;
        parBit    = 1'b0;
        rst       = 1'b0;
        #1 rst    = 1'b1;
        #1;
        checkOutput("resetTx", txOut, 1'b1);
        checkOutput("resetBusy", busy, 1'b0);
        checkOutput("resetDone", frameDone, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("resetHoldTx", txOut, 1'b1);
        checkOutput("resetHoldBusy", busy, 1'b0);
        checkOutput("resetHoldDone", frameDone, 1'b0);
        rst = 1'b0;
        idleCycles(2, "postReset");

        for (int v = 0; v < 5; v++) begin
            q.delete();
            for (int i = 0; i < vecs[v].expLen; i++) q.push_back(vecs[v].expSeq[i]);
            if (STOP_CYCLES == 2) q.push_back(1'b1);
            applyStimulus(vecs[v].data, vecs[v].pe, vecs[v].pb, q, 1'b0, vecs[v].noiseAt, vecs[v].name);
            idleCycles(3, vecs[v].name);
        end

        // Request held high: frames separated by exactly one idle-high cycle.
        q = modelFrame(8'h55, 1'b0, 1'b0);
        applyStimulus(8'h55, 1'b0, 1'b0, q, 1'b1, -1, "hold1");
        applyStimulus(8'h55, 1'b0, 1'b0, q, 1'b1, -1, "hold2");
        applyStimulus(8'h55, 1'b0, 1'b0, q, 1'b0, -1, "hold3");
        idleCycles(3, "holdEnd");

        // Abort on the fifth data bit; line must recover immediately.
        pData     = 8'hA5;
        parEn     = 1'b1;
        parBit    = 1'b0;
        dataValid = 1'b1;
        @(negedge clk);
        checkOutput("abortStart", txOut, 1'b0);
        dataValid = 1'b0;
        d = 8'hA5;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("abortData[%0d]", k), txOut, d[k]);
        end
        rst = 1'b1;
        #1;
        checkOutput("abortTx", txOut, 1'b1);
        checkOutput("abortBusy", busy, 1'b0);
        checkOutput("abortDone", frameDone, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idleCycles(3, "afterAbort");
        applyStimulus(8'h3C, 1'b1, 1'b0, modelFrame(8'h3C, 1'b1, 1'b0), 1'b0, -1, "cleanAfterAbort");
        idleCycles(2, "cleanAfterAbort");

        for (int r = 0; r < 40; r++) begin
            d     = 8'($urandom);
            pe    = 1'($urandom_range(0, 1));
            pb    = 1'($urandom_range(0, 1));
            q     = modelFrame(d, pe, pb);
            noise = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, q.size() - 2)) : -1;
            applyStimulus(d, pe, pb, q, 1'b0, noise, $sformatf("rand%0d", r));
            idleCycles(int'($urandom_range(0, 2)), $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
